// File: rtl/debug_loader.sv
// Debug-path program loader: takes a length/data/checksum byte frame, writes each
// assembled word to instruction memory, and releases the core only after a verified load.
module debug_loader #(
    parameter int             XLEN      = 32,
    parameter int             DEPTH     = 16,
    parameter int             AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic            dbg_sig,
    output logic            dbg_we,
    output logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    input  logic            dbg_ready,
    output logic            start,
    output logic            load_err,
    output logic [15:0]     words_loaded,
    input  logic            reload
);
    localparam int BPW = XLEN / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [15:0]    DEPTH16 = 16'(DEPTH);
    localparam logic [BCW-1:0] LAST_B  = BCW'(BPW - 1);

    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_len_lo;
    logic [15:0]     r_len;
    logic [BCW-1:0]  r_bcnt;
    logic [XLEN-1:0] r_word;
    logic [7:0]      r_csum;
    logic            r_we, r_sig, r_start, r_err;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_instr;
    logic [15:0]     r_words;

    logic            w_xfer, w_wdone, w_last_byte, w_last_word;
    logic [15:0]     w_len_n;
    logic [XLEN-1:0] w_word;

    assign w_xfer      = rx_valid & rx_ready;
    assign w_wdone     = r_we & dbg_ready;
    assign w_len_n     = {rx_data, r_len_lo};
    assign w_last_byte = (r_bcnt == LAST_B);
    assign w_last_word = ((r_words + 16'd1) == r_len);

    // Incoming byte lands in its little-endian lane of the word being assembled
    always_comb begin
        w_word = r_word;
        w_word[r_bcnt*8 +: 8] = rx_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_LEN_LO;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_ready    = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (w_xfer) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len_n > DEPTH16)     w_state_nxt = S_ERR;
                    else if (w_len_n == 16'd0) w_state_nxt = S_CSUM;
                    else                       w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (w_xfer && w_last_byte) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (w_wdone) w_state_nxt = w_last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (w_xfer) w_state_nxt = (rx_data == r_csum) ? S_RUN : S_ERR;
            end
            S_RUN, S_ERR: begin
                if (reload) w_state_nxt = S_LEN_LO;
            end
            default: w_state_nxt = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_bcnt   <= '0;
            r_word   <= '0;
            r_csum   <= '0;
            r_we     <= 1'b0;
            r_sig    <= 1'b1;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_instr  <= '0;
            r_words  <= '0;
        end else begin
            case (r_state)
                S_LEN_LO: if (w_xfer) r_len_lo <= rx_data;
                S_LEN_HI: if (w_xfer) begin
                    r_len  <= w_len_n;
                    r_bcnt <= '0;
                    if (w_len_n > DEPTH16) begin
                        r_err   <= 1'b1;
                        r_start <= 1'b0;
                        r_sig   <= 1'b1;
                    end
                end
                S_DATA: if (w_xfer) begin
                    r_word <= w_word;
                    r_csum <= r_csum ^ rx_data;
                    if (w_last_byte) begin
                        r_instr <= w_word;
                        r_we    <= 1'b1;
                        r_bcnt  <= '0;
                    end else begin
                        r_bcnt  <= r_bcnt + BCW'(1);
                    end
                end
                S_WRITE: if (w_wdone) begin
                    r_we    <= 1'b0;
                    r_addr  <= r_addr + AW'(1);
                    r_words <= r_words + 16'd1;
                end
                S_CSUM: if (w_xfer) begin
                    if (rx_data == r_csum) begin
                        r_start <= 1'b1;
                        r_sig   <= 1'b0;
                        r_err   <= 1'b0;
                    end else begin
                        r_start <= 1'b0;
                        r_sig   <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                S_RUN, S_ERR: if (reload) begin
                    r_start <= 1'b0;
                    r_sig   <= 1'b1;
                    r_err   <= 1'b0;
                    r_addr  <= BASE_ADDR;
                    r_words <= '0;
                    r_csum  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dbg_sig      = r_sig;
    assign dbg_we       = r_we;
    assign dbg_addr     = r_addr;
    assign dbg_instr    = r_instr;
    assign start        = r_start;
    assign load_err     = r_err;
    assign words_loaded = r_words;
endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: good frame, write stall, bad checksum,
// oversize length, empty frame, reload from RUN and mid-load reset.
module tb_debug_loader;
    logic        clk = 1'b0;
    logic        nrst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        dbg_sig, dbg_we, dbg_ready, start, load_err, reload;
    logic [31:0] dbg_addr, dbg_instr;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    debug_loader #(.XLEN(32), .DEPTH(16), .AW(32), .BASE_ADDR(32'h100)) dut (
        .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .dbg_sig(dbg_sig), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_instr(dbg_instr), .dbg_ready(dbg_ready),
        .start(start), .load_err(load_err), .words_loaded(words_loaded),
        .reload(reload)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nrst && dbg_we && dbg_ready) begin
            wa.push_back(dbg_addr);
            wd.push_back(dbg_instr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rx_timeout", {63'd0, n >= 100}, 64'd0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum);
        logic [7:0] f [10];
        f = '{8'h02, 8'h00, 8'h93, 8'h03, 8'h70, 8'h00, 8'h13, 8'h03, 8'h80, 8'h00};
        foreach (f[i]) send(f[i]);
        send(csum);
    endtask

    task automatic chk_good(input string tag);
        chk({tag, "_start"}, start, 1);
        chk({tag, "_sig"},   dbg_sig, 0);
        chk({tag, "_err"},   load_err, 0);
        chk({tag, "_words"}, words_loaded, 2);
        chk({tag, "_nwr"},   wa.size(), 2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, wa[0], 32'h100);
            chk({tag, "_d0"}, wd[0], 32'h00700393);
            chk({tag, "_a1"}, wa[1], 32'h101);
            chk({tag, "_d1"}, wd[1], 32'h00800313);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sig"},   dbg_sig, 1);
        chk({tag, "_we"},    dbg_we, 0);
        chk({tag, "_addr"},  dbg_addr, 32'h100);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_err"},   load_err, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_rdy"},   rx_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; dbg_ready = 1'b1; reload = 1'b0;
        #23;
        chk_idle("rst");
        chk("rst_instr", dbg_instr, 0);
        #4 nrst = 1'b1;

        // Good frame, memory always ready
        send(8'h02); send(8'h00); send(8'h93); send(8'h03); send(8'h70); send(8'h00);
        send(8'h13); send(8'h03); send(8'h80); send(8'h00);
        chk("pre_start", start, 0);
        send(8'h70);
        chk_good("s1");

        // Reload from RUN
        pulse_reload();
        chk_idle("rl1");

        // First write stalled for 5 cycles
        wa.delete(); wd.delete();
        dbg_ready = 1'b0;
        send(8'h02); send(8'h00); send(8'h93); send(8'h03); send(8'h70); send(8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("st_we",    dbg_we, 1);
            chk("st_addr",  dbg_addr, 32'h100);
            chk("st_instr", dbg_instr, 32'h00700393);
            chk("st_rdy",   rx_ready, 0);
        end
        dbg_ready = 1'b1;
        send(8'h13); send(8'h03); send(8'h80); send(8'h00); send(8'h70);
        chk_good("s2");
        pulse_reload();

        // Bad checksum
        wa.delete(); wd.delete();
        send_frame(8'h71);
        chk("bc_nwr",   wa.size(), 2);
        chk("bc_err",   load_err, 1);
        chk("bc_start", start, 0);
        chk("bc_sig",   dbg_sig, 1);
        chk("bc_rdy",   rx_ready, 0);
        pulse_reload();
        chk("bcr_err",  load_err, 0);
        chk("bcr_rdy",  rx_ready, 1);
        chk("bcr_addr", dbg_addr, 32'h100);

        // Oversize length
        wa.delete(); wd.delete();
        send(8'h11); send(8'h00);
        chk("ov_err", load_err, 1);
        chk("ov_rdy", rx_ready, 0);
        chk("ov_we",  dbg_we, 0);
        repeat (3) @(posedge clk);
        #1 chk("ov_nwr", wa.size(), 0);
        chk("ov_hold", load_err, 1);
        pulse_reload();

        // Empty frame
        send(8'h00); send(8'h00);
        chk("e_pre", start, 0);
        send(8'h00);
        chk("e_start", start, 1);
        chk("e_words", words_loaded, 0);
        chk("e_nwr",   wa.size(), 0);
        pulse_reload();

        // Good load, then reset mid-frame, then clean reload
        wa.delete(); wd.delete();
        send_frame(8'h70);
        chk_good("s6");
        pulse_reload();
        chk("rl6_start", start, 0);
        chk("rl6_sig",   dbg_sig, 1);
        send(8'h02); send(8'h00); send(8'h93); send(8'h03); send(8'h70);
        nrst = 1'b0;
        #1;
        chk_idle("mrst");
        @(negedge clk);
        nrst = 1'b1;
        wa.delete(); wd.delete();
        send_frame(8'h70);
        chk_good("s7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
- Parametrised program loader for the debug path. Receives a program image as a framed byte stream: length, data words, checksum.
- Assembles each word and writes it to instruction memory over a valid/ready write port, holding the core in debug/load mode meanwhile.
- Asserts start only after a verified load. Supports reload without a reset and flags length or checksum errors.

Parameters:
- XLEN, 32, instruction word width in bits; must be a multiple of 8; BPW = XLEN/8 bytes per word.
- DEPTH, 16, maximum number of words accepted per load.
- AW, 32, width of dbg_addr.
- BASE_ADDR, 0, word address of the first loaded instruction; addresses step by 1 per word.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts the byte this cycle (transfer = rx_valid & rx_ready)
- dbg_sig  out  1  high = core held, memory port owned by loader
- dbg_we  out  1  write request to instruction memory
- dbg_addr  out  AW  write word address
- dbg_instr  out  XLEN  write data
- dbg_ready  in  1  memory accepts write (write completes when dbg_we & dbg_ready)
- start  out  1  level; program verified, core may run
- load_err  out  1  level; last load failed
- words_loaded  out  16  count of words written in the current/last load
- reload  in  1  single-cycle request to restart loading from RUN or ERR

Behaviour:
- Reset is asynchronous and active-low (nrst); clock is clk. Reset values: dbg_sig=1, dbg_we=0, dbg_addr=BASE_ADDR, dbg_instr=0, start=0, load_err=0, words_loaded=0, state=LEN_LO, internal checksum=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*BPW data bytes (each word little-endian, LSB first), then 1 checksum byte = XOR of all data bytes only.
- rx_ready is a combinational function of state: 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in WRITE, RUN, ERR.
- LEN_LO: on transfer, latch the low byte -> LEN_HI.
- LEN_HI: on transfer, form N.
  - N > DEPTH -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA, with byte counter = 0.
- DATA: on each transfer, shift the byte into the word assembly register at byte lane = byte counter, and XOR it into the checksum.
  - On byte BPW-1: load dbg_instr with the completed word, set dbg_we=1 on the next clock edge -> WRITE.
- WRITE: dbg_we, dbg_addr and dbg_instr are held stable until dbg_ready.
  - On the dbg_we & dbg_ready cycle: dbg_we=0, dbg_addr+=1, words_loaded+=1.
  - If words_loaded+1 == N -> CSUM, else -> DATA.
  - No rx bytes are accepted in WRITE (backpressure).
- CSUM: on transfer, compare rx_data with the checksum.
  - Match -> RUN.
  - Mismatch -> ERR.
- RUN: start=1 and dbg_sig=0, both registered, effective the cycle after the checksum byte transfer. load_err=0.
- ERR: load_err=1, start=0, dbg_sig=1. The state holds until reload.
- Reload: reload=1 in RUN or ERR causes the following on the next edge:
  - state -> LEN_LO, start=0, dbg_sig=1, load_err=0.
  - dbg_addr=BASE_ADDR, words_loaded=0, checksum=0.
  - reload is ignored in all other states.
- Address arithmetic wraps modulo 2^AW. words_loaded saturates naturally since N <= DEPTH.
- Reset mid-operation: any assertion of nrst aborts immediately to the reset values. A partially written program is left in memory, and start stays 0 until a full valid frame has loaded.
- A new load always restarts at BASE_ADDR; no append mode.

Test Plan:
- XLEN=32, DEPTH=16, BASE_ADDR=0x100. Stream 02 00 93 03 70 00 13 03 80 00 70 with dbg_ready=1 -> writes 0x00700393@0x100 and 0x00800313@0x101; start=1 and dbg_sig=0 one cycle after the 0x70 byte; words_loaded=2; load_err=0.
- Same stream with dbg_ready=0 for 5 cycles during the first write -> dbg_we, dbg_addr=0x100 and dbg_instr=0x00700393 held stable; rx_ready=0 throughout; completion once dbg_ready=1; final result identical to the first scenario.
- Same stream with checksum 0x71 -> both words written, then load_err=1, start=0, dbg_sig=1; reload pulse -> load_err=0, rx_ready=1, dbg_addr=0x100.
- Stream 11 00 (N=17 > DEPTH) -> ERR immediately after the second byte; dbg_we never asserted; rx_ready=0.
- Stream 00 00 00 -> no writes; start=1 after the third byte; words_loaded=0.
- Run the first scenario, then pulse reload in RUN -> start=0 and dbg_sig=1 next cycle. Then assert nrst after 3 data bytes -> all outputs return to reset values at once; a subsequent full valid frame loads correctly.
